// File: rtl/writeback_stage_pkg.sv
// rtl/writeback_stage_pkg.sv - shared load-type and writeback FSM encodings
package writeback_stage_pkg;

    typedef logic [2:0] load_type_t;

    localparam load_type_t LOAD_LB  = 3'b000;
    localparam load_type_t LOAD_LH  = 3'b001;
    localparam load_type_t LOAD_LW  = 3'b010;
    localparam load_type_t LOAD_LBU = 3'b100;
    localparam load_type_t LOAD_LHU = 3'b101;

    localparam logic [1:0] WB_IDLE   = 2'd0;
    localparam logic [1:0] WB_WAIT   = 2'd1;
    localparam logic [1:0] WB_COMMIT = 2'd2;

endpackage

// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - memory-to-writeback instruction handshake
interface writeback_stage_if;
    import writeback_stage_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wb_reg_file;
    logic        in_wb_load;
    load_type_t  in_load_type;
    logic [31:0] in_alu_result;

    modport master (
        output in_valid, in_rd, in_wb_reg_file, in_wb_load, in_load_type, in_alu_result,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rd, in_wb_reg_file, in_wb_load, in_load_type, in_alu_result,
        output in_ready
    );

endinterface

// File: rtl/writeback_stage_load_extend.sv
// rtl/writeback_stage_load_extend.sv - lane select, sign/zero extension and alignment check for loads
module load_extend
    import writeback_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  load_type_t  i_load_type,
    output logic [31:0] o_data,
    output logic        o_misaligned
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

        // Unused funct3 encodings fall through to the word case.
        case (i_load_type)
            LOAD_LB: begin
                o_data       = {{24{w_byte[7]}}, w_byte};
                o_misaligned = 1'b0;
            end
            LOAD_LBU: begin
                o_data       = {24'd0, w_byte};
                o_misaligned = 1'b0;
            end
            LOAD_LH: begin
                o_data       = {{16{w_half[15]}}, w_half};
                o_misaligned = i_addr[0];
            end
            LOAD_LHU: begin
                o_data       = {16'd0, w_half};
                o_misaligned = i_addr[0];
            end
            default: begin
                o_data       = i_rdata;
                o_misaligned = (i_addr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - RISC-V writeback: load wait with timeout, extension, register-file write, retire count
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RETIRE_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    writeback_stage_if.slave    in_if,
    input  logic                dmem_rvalid,
    input  logic [31:0]         dmem_rdata,
    output logic                reg_file_wr_en,
    output logic [4:0]          reg_file_wr_addr,
    output logic [31:0]         reg_file_wr_data,
    output logic                load_fault,
    output logic [RETIRE_W-1:0] retire_count
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]          r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_wait_cnt, w_cnt_nxt;
    logic [4:0]          r_rd, w_rd_nxt;
    logic                r_wb_reg_file, w_wbrf_nxt;
    load_type_t          r_load_type, w_lt_nxt;
    logic [1:0]          r_addr_lo, w_addr_nxt;
    logic                r_wr_en, w_wr_en_nxt;
    logic [4:0]          r_wr_addr, w_wr_addr_nxt;
    logic [31:0]         r_wr_data, w_wr_data_nxt;
    logic                r_load_fault, w_fault_nxt;
    logic [RETIRE_W-1:0] r_retire, w_retire_nxt;
    logic                r_in_ready;

    logic                w_in_wait;
    load_type_t          w_ext_type;
    logic [1:0]          w_ext_addr;
    logic [31:0]         w_ext_data;
    logic                w_misaligned;

    // While waiting, extraction uses the held load; otherwise it checks the incoming one.
    assign w_in_wait  = (r_state == WB_WAIT);
    assign w_ext_type = w_in_wait ? r_load_type : in_if.in_load_type;
    assign w_ext_addr = w_in_wait ? r_addr_lo   : in_if.in_alu_result[1:0];

    load_extend u_load_extend (
        .i_rdata      (dmem_rdata),
        .i_addr       (w_ext_addr),
        .i_load_type  (w_ext_type),
        .o_data       (w_ext_data),
        .o_misaligned (w_misaligned)
    );

    // Commit outputs are computed on the edge that enters COMMIT so they are flop-driven during it.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_wait_cnt;
        w_rd_nxt      = r_rd;
        w_wbrf_nxt    = r_wb_reg_file;
        w_lt_nxt      = r_load_type;
        w_addr_nxt    = r_addr_lo;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_fault_nxt   = 1'b0;
        w_retire_nxt  = r_retire;

        if (w_in_wait) begin
            w_cnt_nxt = r_wait_cnt + 1'b1;
            if (dmem_rvalid) begin
                w_state_nxt  = WB_COMMIT;
                w_retire_nxt = r_retire + 1'b1;
                if (r_wb_reg_file && (r_rd != 5'd0)) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = r_rd;
                    w_wr_data_nxt = w_ext_data;
                end
            end else if (r_wait_cnt == CNT_LAST) begin
                w_state_nxt = WB_IDLE;
                w_fault_nxt = 1'b1;
            end
        end else if (in_if.in_valid) begin
            w_rd_nxt   = in_if.in_rd;
            w_wbrf_nxt = in_if.in_wb_reg_file;
            w_lt_nxt   = in_if.in_load_type;
            w_addr_nxt = in_if.in_alu_result[1:0];
            w_cnt_nxt  = '0;
            if (in_if.in_wb_load && !w_misaligned) begin
                w_state_nxt = WB_WAIT;
            end else begin
                w_state_nxt  = WB_COMMIT;
                w_retire_nxt = r_retire + 1'b1;
                w_fault_nxt  = in_if.in_wb_load;
                if (in_if.in_wb_reg_file && (in_if.in_rd != 5'd0) && !in_if.in_wb_load) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = in_if.in_rd;
                    w_wr_data_nxt = in_if.in_alu_result;
                end
            end
        end else begin
            w_state_nxt = WB_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= WB_IDLE;
            r_wait_cnt    <= '0;
            r_rd          <= '0;
            r_wb_reg_file <= 1'b0;
            r_load_type   <= '0;
            r_addr_lo     <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_load_fault  <= 1'b0;
            r_retire      <= '0;
            r_in_ready    <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_cnt_nxt;
            r_rd          <= w_rd_nxt;
            r_wb_reg_file <= w_wbrf_nxt;
            r_load_type   <= w_lt_nxt;
            r_addr_lo     <= w_addr_nxt;
            r_wr_en       <= w_wr_en_nxt;
            r_wr_addr     <= w_wr_addr_nxt;
            r_wr_data     <= w_wr_data_nxt;
            r_load_fault  <= w_fault_nxt;
            r_retire      <= w_retire_nxt;
            r_in_ready    <= (w_state_nxt != WB_WAIT);
        end
    end

    assign in_if.in_ready   = r_in_ready;
    assign reg_file_wr_en   = r_wr_en;
    assign reg_file_wr_addr = r_wr_addr;
    assign reg_file_wr_data = r_wr_data;
    assign load_fault       = r_load_fault;
    assign retire_count     = r_retire;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - randomized self-checking bench for writeback_stage
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        load_fault;
    logic [31:0] retire_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_retire;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    always #5 clk = ~clk;

    writeback_stage_if in_if ();

    writeback_stage #(.TIMEOUT_CYCLES(16), .RETIRE_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_if            (in_if),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .reg_file_wr_en   (wr_en),
        .reg_file_wr_addr (wr_addr),
        .reg_file_wr_data (wr_data),
        .load_fault       (load_fault),
        .retire_count     (retire_count)
    );

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] lt);
        logic [31:0] b = (w >> (8 * a)) & 32'hFF;
        logic [31:0] h = (w >> (16 * a[1])) & 32'hFFFF;
        if (lt == 3'd0) return (b >= 128) ? b - 32'd256 : b;
        if (lt == 3'd4) return b;
        if (lt == 3'd1) return (h >= 32768) ? h - 32'd65536 : h;
        if (lt == 3'd5) return h;
        return w;
    endfunction

    function automatic logic model_misaligned(input logic [2:0] lt, input logic [1:0] a);
        int sz = (lt == 3'd0 || lt == 3'd4) ? 1 : (lt == 3'd1 || lt == 3'd5) ? 2 : 4;
        return (int'(a) % sz) != 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] rd, input logic wbrf, input logic wbl,
                             input logic [2:0] lt, input logic [31:0] addr);
        in_if.in_valid       = 1'b1;
        in_if.in_rd          = rd;
        in_if.in_wb_reg_file = wbrf;
        in_if.in_wb_load     = wbl;
        in_if.in_load_type   = lt;
        in_if.in_alu_result  = addr;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_if.in_valid = 1'b0;
        set_instr(5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
        in_if.in_valid = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = 32'd0;
        repeat (2) tick();
        checks++;
        if ({wr_en, wr_addr, wr_data, load_fault, retire_count, in_if.in_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got en=%b addr=%0d data=%h fault=%b ret=%0d rdy=%b exp all zero rdy=1",
                     wr_en, wr_addr, wr_data, load_fault, retire_count, in_if.in_ready);
        end
        rst = 1'b1;
        exp_retire = 0; exp_addr = 0; exp_data = 0;
        tick();
    endtask

    task automatic test_alu_write();
        set_instr(5'd5, 1'b1, 1'b0, 3'd0, 32'h1234);
        tick();
        in_if.in_valid = 1'b0;
        exp_retire++; exp_addr = 5'd5; exp_data = 32'h1234;
        checks++;
        if ({wr_en, wr_addr, wr_data, retire_count} !== {1'b1, 5'd5, 32'h0000_1234, 32'd1}) begin
            errors++;
            $display("FAIL alu_write: got en=%b addr=%0d data=%h ret=%0d exp en=1 addr=5 data=00001234 ret=1",
                     wr_en, wr_addr, wr_data, retire_count);
        end
        tick();
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b0, 5'd5, 32'h1234}) begin
            errors++;
            $display("FAIL alu_hold: got en=%b addr=%0d data=%h exp en=0 addr=5 data=00001234", wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_x0_store();
        set_instr(5'd0, 1'b1, 1'b0, 3'd0, $urandom);
        tick();
        checks++;
        if (wr_en !== 1'b0) begin errors++; $display("FAIL x0_write: got en=%b exp 0", wr_en); end
        set_instr(5'd7, 1'b0, 1'b0, 3'd0, $urandom);
        tick();
        in_if.in_valid = 1'b0;
        exp_retire += 2;
        checks++;
        if ({wr_en, wr_addr, wr_data, retire_count} !== {1'b0, exp_addr, exp_data, exp_retire}) begin
            errors++;
            $display("FAIL store_no_write: got en=%b addr=%0d data=%h ret=%0d exp en=0 addr=%0d data=%h ret=%0d",
                     wr_en, wr_addr, wr_data, retire_count, exp_addr, exp_data, exp_retire);
        end
        tick();
    endtask

    task automatic test_lb_signed();
        set_instr(5'd12, 1'b1, 1'b1, 3'd0, 32'h0000_1003);
        tick();
        in_if.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_if.in_ready !== 1'b0 || wr_en !== 1'b0) begin
                errors++;
                $display("FAIL lb_wait_%0d: got rdy=%b en=%b exp rdy=0 en=0", k, in_if.in_ready, wr_en);
            end
            if (k == 2) begin dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_7F01; end
            tick();
        end
        dmem_rvalid = 1'b0;
        exp_retire++; exp_addr = 5'd12; exp_data = 32'hFFFF_FF80;
        checks++;
        if ({wr_en, wr_addr, wr_data, retire_count, in_if.in_ready} !== {1'b1, 5'd12, 32'hFFFF_FF80, exp_retire, 1'b1}) begin
            errors++;
            $display("FAIL lb_signed: got en=%b addr=%0d data=%h ret=%0d rdy=%b exp en=1 addr=12 data=ffffff80 ret=%0d rdy=1",
                     wr_en, wr_addr, wr_data, retire_count, in_if.in_ready, exp_retire);
        end
        tick();
    endtask

    task automatic test_halfword();
        set_instr(5'd13, 1'b1, 1'b1, 3'd5, 32'h0000_0022);
        tick();
        in_if.in_valid = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hABCD_0000;
        tick();
        dmem_rvalid = 1'b0;
        exp_retire++; exp_addr = 5'd13; exp_data = 32'h0000_ABCD;
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd13, 32'h0000_ABCD}) begin
            errors++;
            $display("FAIL lhu_data: got en=%b addr=%0d data=%h exp en=1 addr=13 data=0000abcd", wr_en, wr_addr, wr_data);
        end
        set_instr(5'd14, 1'b1, 1'b1, 3'd1, 32'h0000_0041);
        tick();
        in_if.in_valid = 1'b0;
        exp_retire++;
        checks++;
        if ({wr_en, load_fault, retire_count, wr_addr, wr_data} !== {1'b0, 1'b1, exp_retire, exp_addr, exp_data}) begin
            errors++;
            $display("FAIL lh_misaligned: got en=%b fault=%b ret=%0d addr=%0d data=%h exp en=0 fault=1 ret=%0d addr=%0d data=%h",
                     wr_en, load_fault, retire_count, wr_addr, wr_data, exp_retire, exp_addr, exp_data);
        end
        tick();
        checks++;
        if (load_fault !== 1'b0) begin errors++; $display("FAIL lh_fault_pulse: got fault=%b exp 0", load_fault); end
    endtask

    task automatic test_timeout();
        set_instr(5'd9, 1'b1, 1'b1, 3'd2, 32'h0000_0200);
        tick();
        in_if.in_valid = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if (in_if.in_ready !== 1'b0 || load_fault !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait_%0d: got rdy=%b fault=%b exp rdy=0 fault=0", k, in_if.in_ready, load_fault);
            end
        end
        tick();
        checks++;
        if ({load_fault, wr_en, in_if.in_ready, retire_count} !== {1'b1, 1'b0, 1'b1, exp_retire}) begin
            errors++;
            $display("FAIL timeout_abort: got fault=%b en=%b rdy=%b ret=%0d exp fault=1 en=0 rdy=1 ret=%0d",
                     load_fault, wr_en, in_if.in_ready, retire_count, exp_retire);
        end
        dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        tick();
        dmem_rvalid = 1'b0;
        checks++;
        if ({load_fault, wr_en, in_if.in_ready, retire_count} !== {1'b0, 1'b0, 1'b1, exp_retire}) begin
            errors++;
            $display("FAIL timeout_late_rvalid: got fault=%b en=%b rdy=%b ret=%0d exp fault=0 en=0 rdy=1 ret=%0d",
                     load_fault, wr_en, in_if.in_ready, retire_count, exp_retire);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            exp_addr = 5'($urandom_range(1, 31));
            exp_data = $urandom;
            set_instr(exp_addr, 1'b1, 1'b0, 3'($urandom), exp_data);
            tick();
            exp_retire++;
            checks++;
            if ({wr_en, wr_addr, wr_data, in_if.in_ready, retire_count} !== {1'b1, exp_addr, exp_data, 1'b1, exp_retire}) begin
                errors++;
                $display("FAIL b2b_%0d: got en=%b addr=%0d data=%h rdy=%b ret=%0d exp en=1 addr=%0d data=%h rdy=1 ret=%0d",
                         i, wr_en, wr_addr, wr_data, in_if.in_ready, retire_count, exp_addr, exp_data, exp_retire);
            end
        end
        in_if.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [4:0]  rd;
        logic        wbrf, wbl, mis, exp_we;
        logic [2:0]  lt;
        logic [31:0] addr, rdata, val;
        int          dly, gap;
        for (int n = 0; n < 80; n++) begin
            rd = 5'($urandom); wbrf = 1'($urandom); wbl = 1'($urandom); lt = 3'($urandom);
            addr = $urandom; rdata = $urandom; dly = $urandom_range(0, 4);
            mis = wbl && model_misaligned(lt, addr[1:0]);
            exp_we = wbrf && (rd != 0) && !mis;
            val = wbl ? model_load(rdata, addr[1:0], lt) : addr;
            set_instr(rd, wbrf, wbl, lt, addr);
            dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
            tick();
            in_if.in_valid = 1'b0;
            dmem_rvalid = 1'b0;
            if (wbl && !mis) begin
                for (int k = 0; k <= dly; k++) begin
                    checks++;
                    if (in_if.in_ready !== 1'b0 || wr_en !== 1'b0) begin
                        errors++;
                        $display("FAIL rnd_wait_%0d: got rdy=%b en=%b exp rdy=0 en=0", n, in_if.in_ready, wr_en);
                    end
                    in_if.in_valid = (k < dly) ? 1'($urandom) : 1'b0;
                    in_if.in_alu_result = $urandom;
                    if (k == dly) begin dmem_rvalid = 1'b1; dmem_rdata = rdata; end
                    tick();
                end
                dmem_rvalid = 1'b0;
            end
            if (exp_we) begin exp_addr = rd; exp_data = val; end
            exp_retire++;
            checks++;
            if ({wr_en, wr_addr, wr_data, load_fault, retire_count, in_if.in_ready} !==
                {exp_we, exp_addr, exp_data, mis, exp_retire, 1'b1}) begin
                errors++;
                $display("FAIL rnd_commit_%0d: got en=%b addr=%0d data=%h fault=%b ret=%0d exp en=%b addr=%0d data=%h fault=%b ret=%0d",
                         n, wr_en, wr_addr, wr_data, load_fault, retire_count, exp_we, exp_addr, exp_data, mis, exp_retire);
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
                tick();
                dmem_rvalid = 1'b0;
                checks++;
                if ({wr_en, load_fault, retire_count} !== {1'b0, 1'b0, exp_retire}) begin
                    errors++;
                    $display("FAIL rnd_idle_%0d: got en=%b fault=%b ret=%0d exp en=0 fault=0 ret=%0d",
                             n, wr_en, load_fault, retire_count, exp_retire);
                end
            end
        end
        in_if.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        set_instr(5'd3, 1'b1, 1'b1, 3'd2, 32'h0000_0100);
        tick();
        in_if.in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, load_fault, retire_count, in_if.in_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_wait: got en=%b addr=%0d data=%h fault=%b ret=%0d rdy=%b exp all zero rdy=1",
                     wr_en, wr_addr, wr_data, load_fault, retire_count, in_if.in_ready);
        end
        tick();
        rst = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        tick();
        dmem_rvalid = 1'b0;
        checks++;
        if ({wr_en, retire_count, in_if.in_ready} !== {1'b0, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_late_rvalid: got en=%b ret=%0d rdy=%b exp en=0 ret=0 rdy=1", wr_en, retire_count, in_if.in_ready);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu_write();
        test_x0_store();
        test_lb_signed();
        test_halfword();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
